// File: rtl/uart_pkg.sv
// Package: uart_pkg
// Shared types and constants for the UART baud-rate generator.
//  - baud_sel_t : run-time baud selector encoding (00=9600 .. 11=115200)
//  - BAUD_*_HZ  : baud constants in bits per second
//  - OVERSAMPLE : rx_tick periods per tx_tick period
//  - baud_hz()  : selector -> baud rate
//  - calc_div() : clock divisor for the 16x oversampling strobe
package uart_pkg;

  typedef enum logic [1:0] {
    BAUD_9600   = 2'b00,
    BAUD_19200  = 2'b01,
    BAUD_57600  = 2'b10,
    BAUD_115200 = 2'b11
  } baud_sel_t;

  localparam int unsigned BAUD_9600_HZ   = 9600;
  localparam int unsigned BAUD_19200_HZ  = 19200;
  localparam int unsigned BAUD_57600_HZ  = 57600;
  localparam int unsigned BAUD_115200_HZ = 115200;

  localparam int unsigned OVERSAMPLE = 16;

  function automatic logic [31:0] baud_hz(input baud_sel_t sel);
    logic [31:0] hz;
    case (sel)
      BAUD_9600:   hz = BAUD_9600_HZ;
      BAUD_19200:  hz = BAUD_19200_HZ;
      BAUD_57600:  hz = BAUD_57600_HZ;
      BAUD_115200: hz = BAUD_115200_HZ;
      default:     hz = BAUD_9600_HZ;
    endcase
    return hz;
  endfunction

  // Divisor rounded to nearest: (freq + os*baud/2) / (os*baud).
  // A zero result clamps to 1 (tick every cycle); results wider than
  // 16 bits saturate rather than wrapping to a tiny divisor.
  function automatic logic [15:0] calc_div(input logic [31:0] freq,
                                           input logic [31:0] baud);
    logic [31:0] q;
    q = (freq + baud * 32'(OVERSAMPLE / 2)) / (baud * 32'(OVERSAMPLE));
    if (q == 32'd0)
      return 16'd1;
    else if (q > 32'h0000_FFFF)
      return 16'hFFFF;
    else
      return q[15:0];
  endfunction

endpackage

// File: rtl/uart_brg_div.sv
// Module: uart_brg_div
// Generic modulo-N pulse counter. While en is high the counter steps
// 0..n-1 and wraps; pulse is high for the enabled cycle in which the count
// sits at (or beyond) n-1. The ">=" compare lets a divisor that shrinks
// mid-period end the period at once instead of running past the new limit.
// Ports:
//  clk   in       clock, rising edge
//  rst   in       asynchronous, active-high reset (clears count, forces pulse low)
//  en    in       count enable
//  n     in  N_W  modulus (0 is treated as 1)
//  clr   in       synchronous clear; suppresses pulse in the same cycle
//  pulse out      terminal-count strobe (combinational decode of the count)
module uart_brg_div #(
  parameter int CNT_W = 16,  // must not exceed N_W
  parameter int N_W   = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [N_W-1:0] n,
  input  logic           clr,
  output logic           pulse
);

  logic [CNT_W-1:0] cnt;
  logic [N_W-1:0]   last;
  logic             at_last;

  always_comb begin
    // NOTE: every always_comb output gets a value on every path; a missing
    // else or default would infer a latch.
    last    = (n == '0) ? '0 : n - N_W'(1);
    at_last = (N_W'(cnt) >= last);
    pulse   = en & at_last & ~clr & ~rst;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= at_last ? '0 : cnt + CNT_W'(1);
  end

endmodule

// File: rtl/uart_brg.sv
// Module: uart_brg
// UART baud-rate generator. Divides clk into a 16x oversampling strobe for
// the receiver (rx_tick) and a 1x bit strobe for the transmitter (tx_tick).
// tx_tick is always coincident with an rx_tick; tx period = 16*div clocks.
// Ports:
//  clk       in     system clock, rising edge
//  rst       in     asynchronous, active-high reset
//  baud_sel  in  2  00=9600, 01=19200, 10=57600, 11=115200 baud
//  rx_tick   out    one-clk pulse at 16x baud
//  tx_tick   out    one-clk pulse at 1x baud
// Configuration macro UART_BRG_SYNC_RESTART_EN:
//  defined   - any baud_sel change clears both counters on the next edge and
//              suppresses ticks for that cycle, so the new rate starts cleanly.
//  undefined - the new divisor applies immediately; tx phase is kept.
module uart_brg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int OVERSAMPLE  = uart_pkg::OVERSAMPLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] baud_sel,
  output logic       rx_tick,
  output logic       tx_tick
);

  localparam int TX_W = $clog2(OVERSAMPLE);

  // Never written after the initialiser, so synthesis folds the divisor
  // into a constant per selector; simulation may override it for corner cases.
  logic [31:0] freq = 32'(CLK_FREQ_HZ);

  logic [15:0] div;
  logic        clr;

  assign div = calc_div(freq, baud_hz(baud_sel_t'(baud_sel)));

`ifdef UART_BRG_SYNC_RESTART_EN
  logic [1:0] sel_q;

  // NOTE: sel_q is deliberately left without reset; it keeps tracking
  // baud_sel while rst is held, so releasing reset never looks like a
  // selector change and never triggers a spurious restart.
  always_ff @(posedge clk) begin
    sel_q <= baud_sel;
  end

  assign clr = (sel_q != baud_sel);
`else
  assign clr = 1'b0;
`endif

  uart_brg_div #(
    .CNT_W (16),
    .N_W   (16)
  ) u_rx_div (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .n     (div),
    .clr   (clr),
    .pulse (rx_tick)
  );

  // Counts rx ticks; its terminal pulse lands on the rx tick that wraps it.
  uart_brg_div #(
    .CNT_W (TX_W),
    .N_W   (16)
  ) u_tx_div (
    .clk   (clk),
    .rst   (rst),
    .en    (rx_tick),
    .n     (16'(OVERSAMPLE)),
    .clr   (clr),
    .pulse (tx_tick)
  );

endmodule

// File: tb/tb_uart_brg.sv
// Testbench: tb_uart_brg
// Scoreboarded bench for uart_brg. Five instances share one clock:
//  dut0 - 10 MHz, selector driven by the stimulus (rate switches, resets)
//  dut1..dut3 - 10 MHz, fixed selectors 01/10/11
//  dut4 - freq overridden to 160 Hz, selector 11 (divisor clamps to 1)
// The stimulus computes every expected tick (cycle number and whether it is
// also a tx tick) from the baud formula and pushes it into a per-instance
// queue; a monitor on the falling edge pops and compares whenever a DUT ticks.
module tb_uart_brg;

  localparam int SYS_HZ = 10_000_000;

  typedef struct {
    int cyc;
    bit tx;
  } tick_t;

  logic       clk = 1'b0;
  logic       rst0 = 1'b1;
  logic       rst_par = 1'b1;
  logic [1:0] sel0 = 2'b00;
  logic [4:0] rx_v;
  logic [4:0] tx_v;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int n_rx[5];
  tick_t exp_q[5][$];

  int baud_tab[4]  = '{9600, 19200, 57600, 115200};
  int inst_freq[5] = '{SYS_HZ, SYS_HZ, SYS_HZ, SYS_HZ, 160};
  int inst_sel[5]  = '{0, 1, 2, 3, 3};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_brg #(.CLK_FREQ_HZ(SYS_HZ)) dut0 (.clk(clk), .rst(rst0),    .baud_sel(sel0),  .rx_tick(rx_v[0]), .tx_tick(tx_v[0]));
  uart_brg #(.CLK_FREQ_HZ(SYS_HZ)) dut1 (.clk(clk), .rst(rst_par), .baud_sel(2'b01), .rx_tick(rx_v[1]), .tx_tick(tx_v[1]));
  uart_brg #(.CLK_FREQ_HZ(SYS_HZ)) dut2 (.clk(clk), .rst(rst_par), .baud_sel(2'b10), .rx_tick(rx_v[2]), .tx_tick(tx_v[2]));
  uart_brg #(.CLK_FREQ_HZ(SYS_HZ)) dut3 (.clk(clk), .rst(rst_par), .baud_sel(2'b11), .rx_tick(rx_v[3]), .tx_tick(tx_v[3]));
  uart_brg #(.CLK_FREQ_HZ(SYS_HZ)) dut4 (.clk(clk), .rst(rst_par), .baud_sel(2'b11), .rx_tick(rx_v[4]), .tx_tick(tx_v[4]));

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference divisor: round-to-nearest of freq / (16*baud), at least 1.
  function automatic int ref_div(input int f, input int sel);
    longint q;
    q = (longint'(f) + 8 * longint'(baud_tab[sel])) / (16 * longint'(baud_tab[sel]));
    if (q < 1) q = 1;
    if (q > 65535) q = 65535;
    return int'(q);
  endfunction

  // Expect rx ticks at first, first+d, ... up to last; every 16th rx tick
  // since the tx phase origin is also a tx tick.
  task automatic sched(input int i, input int first, input int d, input int last);
    tick_t e;
    for (int t = first; t <= last; t += d) begin
      n_rx[i]++;
      e.cyc = t;
      e.tx  = (n_rx[i] % 16) == 0;
      exp_q[i].push_back(e);
    end
  endtask

  // Advance n rising edges; inputs change 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Run at sa, switch to sb 'off' cycles after reset release, run 'tail' more.
  task automatic run_switch(input int sa, input int sb, input int off, input int tail);
    int c0, m, da, db, first;
`ifndef UART_BRG_SYNC_RESTART_EN
    int p;
`endif
    rst0 = 1'b1; sel0 = 2'(sa); n_rx[0] = 0;
    step(3);
    rst0 = 1'b0;
    c0 = cyc;
    da = ref_div(SYS_HZ, sa);
    db = ref_div(SYS_HZ, sb);
    m  = c0 + off;
    sched(0, c0 + da - 1, da, m - 1);
`ifdef UART_BRG_SYNC_RESTART_EN
    n_rx[0] = 0;
    first = m + db;
`else
    p = off % da;
    first = (p >= db - 1) ? m : m + (db - 1 - p);
`endif
    sched(0, first, db, m + tail - 1);
    step(off);
    sel0 = 2'(sb);
    step(tail);
    rst0 = 1'b1;
  endtask

  // Reset asserted 'off' cycles into a run at sel, then released again.
  task automatic run_reset_mid(input int sel, input int off, input int tail);
    int c0, c1, d;
    rst0 = 1'b1; sel0 = 2'(sel); n_rx[0] = 0;
    step(3);
    rst0 = 1'b0;
    c0 = cyc;
    d  = ref_div(SYS_HZ, sel);
    sched(0, c0 + d - 1, d, c0 + off - 1);
    step(off);
    rst0 = 1'b1;
    n_rx[0] = 0;
    #1;
    check("rx_tick in mid-period reset", rx_v[0], 0);
    check("tx_tick in mid-period reset", tx_v[0], 0);
    step(4);
    rst0 = 1'b0;
    c1 = cyc;
    sched(0, c1 + d - 1, d, c1 + tail - 1);
    step(tail);
    rst0 = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    tick_t e;
    for (int i = 0; i < 5; i++) begin
      while (exp_q[i].size() > 0 && exp_q[i][0].cyc < cyc) begin
        e = exp_q[i].pop_front();
        check($sformatf("u%0d missing rx_tick (now cycle vs due cycle)", i), cyc, e.cyc);
      end
      if (rx_v[i]) begin
        if (exp_q[i].size() == 0) begin
          check($sformatf("u%0d unexpected rx_tick at cycle %0d", i, cyc), rx_v[i], 0);
        end else begin
          e = exp_q[i].pop_front();
          check($sformatf("u%0d rx_tick cycle", i), cyc, e.cyc);
          check($sformatf("u%0d tx_tick at cycle %0d", i, cyc), tx_v[i], e.tx);
        end
      end else if (tx_v[i]) begin
        check($sformatf("u%0d tx_tick without rx_tick at cycle %0d", i, cyc), tx_v[i], rx_v[i]);
      end
    end
  end

  initial begin : stimulus
    int c0, h, d, sa, sb;
    #1;
    dut4.freq = 32'd160;
    step(3);

    for (int i = 0; i < 5; i++) begin
      check($sformatf("u%0d rx_tick in reset", i), rx_v[i], 0);
      check($sformatf("u%0d tx_tick in reset", i), tx_v[i], 0);
    end

    // All instances released together; three tx periods of the slowest rate.
    h = 3 * 16 * ref_div(SYS_HZ, 0) + 20;
    sel0 = 2'b00;
    rst0 = 1'b0;
    rst_par = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 5; i++) begin
      n_rx[i] = 0;
      d = ref_div(inst_freq[i], inst_sel[i]);
      sched(i, c0 + d - 1, d, c0 + h - 1);
    end
    step(h);
    rst0 = 1'b1;
    rst_par = 1'b1;
    step(3);

    run_reset_mid(1, 100, 33 * 20);
    run_switch(0, 3, 40, 200);

    for (int k = 0; k < 5; k++) begin
      sa = $urandom_range(0, 3);
      sb = (sa + $urandom_range(1, 3)) % 4;
      run_switch(sa, sb, $urandom_range(0, 32 * ref_div(SYS_HZ, sa)),
                 32 * ref_div(SYS_HZ, sb) + $urandom_range(0, 50));
    end
    run_reset_mid($urandom_range(0, 3), $urandom_range(1, 500), 1200);

    step(5);
    for (int i = 0; i < 5; i++)
      check($sformatf("u%0d expected ticks never seen", i), exp_q[i].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
